// File: rtl/rconst_if.sv
// Round-constant handshake bundle between the sequencer and the Keccak-f[200] round datapath.
interface rconst_if;
  logic        start;
  logic        round_ack;
  logic        round_valid;
  logic [17:0] round_onehot;
  logic [7:0]  rc;
  logic        last;
  logic        busy;
  logic        done;

  modport master (
    output start, round_ack,
    input  round_valid, round_onehot, rc, last, busy, done
  );

  modport slave (
    input  start, round_ack,
    output round_valid, round_onehot, rc, last, busy, done
  );
endinterface

// File: rtl/rconst_seq_200.sv
// Sequential Keccak-f[200] round-constant source: LFSR-derived iota constants under a start/ack handshake.
// Optional RCONST_SELFCHECK_EN adds a sticky rc_err output that compares rc against a golden table.
//
// state  | meaning
// S_IDLE | waiting for start, outputs zero
// S_RUN  | round presented, held until round_ack
// S_DONE | one-cycle done pulse, start restarts at once
module rconst_seq_200 #(
  parameter int NR = 18
) (
  input  logic     clk,
  input  logic     reset,
  rconst_if.slave  bus
`ifdef RCONST_SELFCHECK_EN
  ,
  output logic     rc_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [17:0] onehot_q, onehot_d;
  logic [7:0]  rc_q, rc_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  lfsr_adv;
  logic [17:0] onehot_nx;

  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h71 : 8'h00);
  endfunction

  // Round constant taps bits 0,1,3,7 from the first four step outputs.
  function automatic logic [7:0] rc_from(input logic [7:0] r0);
    logic [7:0] r1, r2, r3;
    r1 = lfsr_step(r0);
    r2 = lfsr_step(r1);
    r3 = lfsr_step(r2);
    return {r3[0], 3'b000, r2[0], 1'b0, r1[0], r0[0]};
  endfunction

  always_comb begin
    lfsr_adv = lfsr_q;
    for (int i = 0; i < 7; i++) lfsr_adv = lfsr_step(lfsr_adv);
    onehot_nx = onehot_q << 1;
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    onehot_d = onehot_q;
    rc_d     = rc_q;
    valid_d  = valid_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          lfsr_d   = 8'h01;
          onehot_d = 18'h00001;
          rc_d     = rc_from(8'h01);
          valid_d  = 1'b1;
          last_d   = (NR == 1);
          busy_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.round_ack) begin
          if (last_q) begin
            state_d  = S_DONE;
            lfsr_d   = 8'h01;
            onehot_d = '0;
            rc_d     = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            lfsr_d   = lfsr_adv;
            onehot_d = onehot_nx;
            rc_d     = rc_from(lfsr_adv);
            last_d   = onehot_nx[NR-1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= 8'h01;
      onehot_q <= '0;
      rc_q     <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      onehot_q <= onehot_d;
      rc_q     <= rc_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.round_valid  = valid_q;
  assign bus.round_onehot = onehot_q;
  assign bus.rc           = rc_q;
  assign bus.last         = last_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

`ifdef RCONST_SELFCHECK_EN
  localparam logic [7:0] RC_TAB [18] = '{
    8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
    8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80
  };

  logic       rc_err_q, rc_err_d;
  logic [7:0] rc_exp;

  always_comb begin
    rc_exp = '0;
    for (int i = 0; i < 18; i++) begin
      if (onehot_q[i]) rc_exp = rc_exp | RC_TAB[i];
    end
    rc_err_d = rc_err_q | (valid_q && (rc_q != rc_exp));
  end

  always_ff @(posedge clk) begin
    if (reset) rc_err_q <= 1'b0;
    else       rc_err_q <= rc_err_d;
  end

  assign rc_err = rc_err_q;
`endif

endmodule

// File: tb/tb_rconst_seq_200.sv
// Self-checking bench for rconst_seq_200: golden vector table, directed corner sequences and
// randomized start/ack/reset against a round-level reference model (NR=18 and NR=4 instances).
module tb_rconst_seq_200;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  bit   chk_en;

  rconst_if b18 ();
  rconst_if b4 ();

`ifdef RCONST_SELFCHECK_EN
  logic rc_err18, rc_err4;
  rconst_seq_200 #(.NR(18)) u18 (.clk(clk), .reset(reset), .bus(b18), .rc_err(rc_err18));
  rconst_seq_200 #(.NR(4))  u4  (.clk(clk), .reset(reset), .bus(b4),  .rc_err(rc_err4));
`else
  rconst_seq_200 #(.NR(18)) u18 (.clk(clk), .reset(reset), .bus(b18));
  rconst_seq_200 #(.NR(4))  u4  (.clk(clk), .reset(reset), .bus(b4));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] GOLDEN [18] = '{
    8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
    8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80
  };

  // Round-level reference: index 0 models NR=18, index 1 models NR=4.
  int nrs    [2] = '{18, 4};
  bit m_act  [2];
  int m_rnd  [2];
  bit m_done [2];

  function automatic logic rcbit(input int t);
    logic [8:0] r;
    r = 9'h001;
    for (int i = 0; i < (t % 255); i++) begin
      r = r << 1;
      if (r[8]) r = r ^ 9'h171;
    end
    return r[0];
  endfunction

  function automatic logic [7:0] ref_rc(input int rnd);
    logic [7:0] v;
    int idx;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      idx = (1 << j) - 1;
      v[idx] = rcbit(j + 7 * rnd);
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic s, input logic a, input logic r);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_act[k] = 0; m_rnd[k] = 0; m_done[k] = 0;
      end else if (m_act[k]) begin
        m_done[k] = 0;
        if (a) begin
          if (m_rnd[k] == nrs[k] - 1) begin
            m_act[k] = 0; m_done[k] = 1;
          end else begin
            m_rnd[k]++;
          end
        end
      end else begin
        m_done[k] = 0;
        if (s) begin
          m_act[k] = 1; m_rnd[k] = 0;
        end
      end
    end
  endtask

  task automatic check_one(input int k, input string tag, input logic v, input logic [17:0] oh,
                           input logic [7:0] rc, input logic l, input logic bz, input logic dn);
    logic [17:0] e_oh;
    logic [7:0]  e_rc;
    e_oh = m_act[k] ? (18'h1 << m_rnd[k]) : 18'h0;
    e_rc = m_act[k] ? ref_rc(m_rnd[k]) : 8'h00;
    chk({tag, "_valid"},  {31'd0, v},  {31'd0, m_act[k]});
    chk({tag, "_onehot"}, {14'd0, oh}, {14'd0, e_oh});
    chk({tag, "_rc"},     {24'd0, rc}, {24'd0, e_rc});
    chk({tag, "_last"},   {31'd0, l},  {31'd0, (m_act[k] && m_rnd[k] == nrs[k] - 1)});
    chk({tag, "_busy"},   {31'd0, bz}, {31'd0, m_act[k]});
    chk({tag, "_done"},   {31'd0, dn}, {31'd0, m_done[k]});
  endtask

  task automatic check_all();
    check_one(0, "nr18", b18.round_valid, b18.round_onehot, b18.rc, b18.last, b18.busy, b18.done);
    check_one(1, "nr4",  b4.round_valid,  b4.round_onehot,  b4.rc,  b4.last,  b4.busy,  b4.done);
  endtask

  // Called at a negedge: drive, take one rising edge, advance model, sample at the next negedge.
  task automatic cyc(input logic s, input logic a, input logic r);
    b18.start = s; b18.round_ack = a;
    b4.start  = s; b4.round_ack  = a;
    reset     = r;
    @(posedge clk);
    model_update(s, a, r);
    @(negedge clk);
    if (chk_en) check_all();
  endtask

  typedef struct {
    logic        start;
    logic        ack;
    logic        rst;
    logic        e_valid;
    logic [17:0] e_onehot;
    logic [7:0]  e_rc;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t       vecs [21];
  logic [7:0] seen [$];

  initial begin
    checks = 0; failures = 0; chk_en = 1'b1;
    for (int k = 0; k < 2; k++) begin m_act[k] = 0; m_rnd[k] = 0; m_done[k] = 0; end

    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 18'h1, GOLDEN[0], 1'b0, 1'b1, 1'b0};
    for (int i = 2; i <= 18; i++)
      vecs[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 18'h1 << (i - 1), GOLDEN[i-1], (i == 18), 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 18'h0, 8'h00, 1'b0, 1'b0, 1'b0};

    b18.start = 0; b18.round_ack = 0; b4.start = 0; b4.round_ack = 0; reset = 1'b1;
    @(negedge clk);

    // Golden table: reset, start, ack held high across all 18 rounds.
    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].start, vecs[i].ack, vecs[i].rst);
      chk("tab_valid",  {31'd0, b18.round_valid},  {31'd0, vecs[i].e_valid});
      chk("tab_onehot", {14'd0, b18.round_onehot}, {14'd0, vecs[i].e_onehot});
      chk("tab_rc",     {24'd0, b18.rc},           {24'd0, vecs[i].e_rc});
      chk("tab_last",   {31'd0, b18.last},         {31'd0, vecs[i].e_last});
      chk("tab_busy",   {31'd0, b18.busy},         {31'd0, vecs[i].e_busy});
      chk("tab_done",   {31'd0, b18.done},         {31'd0, vecs[i].e_done});
    end

    // Ack only every third cycle: values hold between acks and appear in golden order.
    cyc(1'b1, 1'b0, 1'b0);
    seen.delete();
    for (int c = 0; c < 60 && seen.size() < 18; c++) begin
      logic a;
      a = (c % 3 == 2);
      if (a) seen.push_back(b18.rc);
      cyc(1'b0, a, 1'b0);
    end
    chk("slow_count", seen.size(), 18);
    for (int i = 0; i < seen.size() && i < 18; i++)
      chk("slow_seq", {24'd0, seen[i]}, {24'd0, GOLDEN[i]});
    chk("slow_done", {31'd0, b18.done}, 32'd1);

    // Start in the DONE cycle restarts round 0 on the following cycle.
    cyc(1'b1, 1'b0, 1'b0);
    chk("b2b_valid",  {31'd0, b18.round_valid},  32'd1);
    chk("b2b_onehot", {14'd0, b18.round_onehot}, 32'd1);
    chk("b2b_rc",     {24'd0, b18.rc},           32'h01);

    // Reset while round 7 is presented: everything clears, no done pulse.
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("r7_rc", {24'd0, b18.rc}, 32'h09);
    cyc(1'b0, 1'b0, 1'b1);
    chk("rst_valid", {31'd0, b18.round_valid}, 32'd0);
    chk("rst_rc",    {24'd0, b18.rc},          32'd0);
    chk("rst_done",  {31'd0, b18.done},        32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst_nodone", {31'd0, b18.done}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_rc", {24'd0, b18.rc}, 32'h01);
    cyc(1'b0, 1'b0, 1'b1);

    // Randomized start/ack/reset; covers start-during-RUN and NR=4 last/done.
    for (int c = 0; c < 3000; c++) begin
      logic s, a, r;
      s = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 149) == 0);
      cyc(s, a, r);
    end

`ifdef RCONST_SELFCHECK_EN
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("selfcheck_clean", {31'd0, rc_err18}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_en = 1'b0;
    begin
      logic [7:0] t;
      t = u18.lfsr_q ^ 8'h10;
      force u18.lfsr_q = t;
      cyc(1'b0, 1'b0, 1'b0);
      release u18.lfsr_q;
    end
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("selfcheck_set", {31'd0, rc_err18}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("selfcheck_sticky", {31'd0, rc_err18}, 32'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("selfcheck_reset", {31'd0, rc_err18}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rconst_seq_200.md
Name: rconst_seq_200

Overview:
- Sequential round-constant source for the Keccak-f[200] permutation core.
- Generates the 18-bit one-hot round index and the 8-bit iota constant, round by round.
- The constant is computed from the spec LFSR (x^8+x^6+x^5+x^4+1), not from a lookup table.
- Uses a start/ack handshake with the permutation datapath: one round is presented and held until the core acknowledges it.

Parameters:
- NR, 18, number of rounds issued per permutation; legal range 1..18; rounds 0..NR-1 are issued.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; forces the IDLE values listed below.
- start  in  1  begin a permutation; sampled only in IDLE or DONE.
- round_ack  in  1  core has consumed the current round; sampled only while round_valid=1.
- round_valid  out  1  round_onehot/rc are valid and held stable until acked.
- round_onehot  out  18  one-hot round index; bit r set for round r; 0 when not valid.
- rc  out  8  round constant; only bits 0,1,3,7 may be nonzero; 0 when not valid.
- last  out  1  round_valid & round_onehot[NR-1].
- busy  out  1  high in RUN.
- done  out  1  single-cycle pulse after the final round is acked.

Behaviour:
- FSM states: IDLE, RUN, DONE. Outputs are registered.
- Reset values: state=IDLE, lfsr=8'h01, round_onehot=0, rc=0, round_valid=0, busy=0, done=0, last=0.
- Reset asserted mid-RUN returns the block to the reset values at that edge. The in-flight permutation is abandoned with no done pulse.
- LFSR step function (R[7]=MSB): R' = {R[6:0],1'b0} ^ (R[7] ? 8'h71 : 8'h00). Step output = R[0].
- Constant derivation for round r: register R holds the state at step t=7r.
  - rc[0] = R0[0], rc[1] = R1[0], rc[3] = R2[0], rc[7] = R3[0], where Rk is R after k steps.
  - All other rc bits are 0.
- Round advance applies 7 steps combinationally to R. This combinational depth is accepted.
- IDLE:
  - start=1 -> RUN next cycle with round_onehot=18'h00001, rc=8'h01, round_valid=1, busy=1.
  - start=0 -> stay in IDLE.
  - round_ack is ignored.
- RUN, round_ack=0: hold all outputs; no stall limit.
- RUN, round_ack=1 and not last: next cycle round_onehot shifts left by 1, R advances 7 steps, rc is recomputed. Result is one round per ack cycle at full rate, with no bubble.
- RUN, round_ack=1 and last: next cycle DONE.
  - done=1, round_valid=0, round_onehot=0, rc=0, busy=0.
  - lfsr reloads to 8'h01.
- DONE (one cycle):
  - start=1 -> RUN round 0 next cycle, giving back-to-back permutations with a one-cycle gap.
  - start=0 -> IDLE.
- start during RUN is ignored. It is not queued.
- NR=1: round 0 is issued with last=1; its ack goes directly to DONE.
- Golden sequence, rounds 0..17: 01 82 8A 00 8B 01 81 09 8A 88 09 0A 8B 8B 89 03 02 80.

Optional Feature:
- Macro RCONST_SELFCHECK_EN.
- Defined:
  - Adds output port rc_err (1 bit, reset 0) and an internal 18-entry constant table holding the golden sequence.
  - Whenever round_valid=1 and rc differs from table[index of round_onehot], rc_err sets on the next edge.
  - rc_err is sticky until reset.
- Undefined: no rc_err port and no table. Functional behaviour is otherwise identical.

Test Plan:
- Reset, then start pulse, then round_ack held high: 18 consecutive cycles with rc = 01,82,8A,00,8B,01,81,09,8A,88,09,0A,8B,8B,89,03,02,80. round_onehot walks bit0..bit17, last=1 only on rc=80, done=1 for exactly one cycle afterwards, busy=0 after.
- Same as above but round_ack asserted only every 3rd cycle: outputs hold stable between acks and the same 18 values appear in order.
- start asserted in the DONE cycle: round_valid=1, round_onehot=1, rc=01 on the following cycle. Second sequence identical to the first.
- reset asserted while round 7 is presented (rc=09): next cycle all outputs 0, no done pulse. A later start restarts from rc=01.
- NR=4: sequence 01,82,8A,00 with last=1 on 00, then done pulse. start pulses during RUN have no effect.
- With RCONST_SELFCHECK_EN: full run leaves rc_err=0. Forcing an lfsr bit flip mid-run sets rc_err=1, and it stays 1 until reset.
